common_bus_datapath: RTL and testbench

- Datapath end of the 8-bit common-bus CPU. It consumes the control strobes the microcode sequencer drives and returns the instruction word and branch flags to it.
- Holds the PC, the 14-bit IR, a 4-entry register file, two ALU source latches and a latched ALU function field.
- A single 8-bit bus, selected by data_bus_sel, feeds every loadable element.

---
 rtl/common_bus_datapath.sv | 139 +++++++++++++
 tb/tb_common_bus_datapath.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/common_bus_datapath.sv
// Datapath half of the 8-bit common-bus CPU: PC, IR, 4-entry register file, ALU latches and flags.
// Optional build macro COMMON_BUS_DP_CYCLE_COUNT_EN adds a 16-bit retired-fetch counter output.
module common_bus_datapath #(
    parameter int DATA_WIDTH = 8,
    parameter int INSTR_WIDTH = 14,
    parameter logic [DATA_WIDTH-1:0] PC_RESET_VAL = 8'h00
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [1:0]             data_bus_sel,
    input  logic [1:0]             reg_address,
    input  logic                   pc_load_en,
    input  logic                   ir_load_en,
    input  logic                   rf_write_read,
    input  logic                   alu_src1_load_en,
    input  logic                   alu_src2_load_en,
    input  logic                   sel_field_load_en,
    output logic [DATA_WIDTH-1:0]  instr_addr,
    input  logic [INSTR_WIDTH-1:0] instr_rdata,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   flag_eq,
    output logic                   flag_lt,
    output logic                   flag_carry,
`ifdef COMMON_BUS_DP_CYCLE_COUNT_EN
    output logic [15:0]            retired_count,
`endif
    output logic [DATA_WIDTH-1:0]  bus_value
);

    localparam logic [2:0] FN_ADD  = 3'b000;
    localparam logic [2:0] FN_SUB  = 3'b001;
    localparam logic [2:0] FN_XOR  = 3'b010;
    localparam logic [2:0] FN_AND  = 3'b011;
    localparam logic [2:0] FN_OR   = 3'b100;
    localparam logic [2:0] FN_PASS = 3'b101;
    localparam logic [2:0] FN_SUB2 = 3'b110;
    localparam logic [2:0] FN_ADD2 = 3'b111;

    logic [DATA_WIDTH-1:0]        pc_reg;
    logic [INSTR_WIDTH-1:0]       ir_reg;
    logic [DATA_WIDTH-1:0]        src1_reg;
    logic [DATA_WIDTH-1:0]        src2_reg;
    logic [2:0]                   func_reg;
    logic [3:0][DATA_WIDTH-1:0]   rf_words;
    logic [DATA_WIDTH-1:0]        rf_rdata;
    logic [DATA_WIDTH:0]          alu_wide;
    logic [DATA_WIDTH-1:0]        alu_result;
    logic                         alu_carry;

    assign rf_rdata = rf_words[reg_address];

    // Bus sources are all registers or logic on registers, so the bus never loops back on itself.
    always_comb begin
        bus_value = pc_reg;
        unique case (data_bus_sel)
            2'b00: bus_value = pc_reg;
            2'b01: bus_value = rf_rdata;
            2'b10: bus_value = alu_result;
            2'b11: bus_value = ir_reg[DATA_WIDTH-1:0];
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rf
            logic [DATA_WIDTH-1:0] word_reg;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    word_reg <= '0;
                else if (rf_write_read && (reg_address == 2'(gi)))
                    word_reg <= bus_value;
            end
            assign rf_words[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg   <= PC_RESET_VAL;
            ir_reg   <= '0;
            src1_reg <= '0;
            src2_reg <= '0;
            func_reg <= FN_ADD;
        end else begin
            if (pc_load_en)
                pc_reg <= bus_value;
            else if (ir_load_en)
                pc_reg <= pc_reg + DATA_WIDTH'(1);
            if (ir_load_en)
                ir_reg <= instr_rdata;
            // Reads the pre-edge IR, so a same-cycle fetch does not affect the latched function.
            if (sel_field_load_en)
                func_reg <= ir_reg[13:11];
            if (alu_src1_load_en)
                src1_reg <= bus_value;
            if (alu_src2_load_en)
                src2_reg <= bus_value;
        end
    end

    // One extra bit captures carry on add and borrow (src1 < src2 unsigned) on subtract.
    always_comb begin
        alu_wide  = '0;
        alu_carry = 1'b0;
        unique case (func_reg)
            FN_ADD, FN_ADD2: begin
                alu_wide  = {1'b0, src1_reg} + {1'b0, src2_reg};
                alu_carry = alu_wide[DATA_WIDTH];
            end
            FN_SUB, FN_SUB2: begin
                alu_wide  = {1'b0, src1_reg} - {1'b0, src2_reg};
                alu_carry = alu_wide[DATA_WIDTH];
            end
            FN_XOR:  alu_wide = {1'b0, src1_reg ^ src2_reg};
            FN_AND:  alu_wide = {1'b0, src1_reg & src2_reg};
            FN_OR:   alu_wide = {1'b0, src1_reg | src2_reg};
            FN_PASS: alu_wide = {1'b0, src2_reg};
        endcase
    end

    assign alu_result  = alu_wide[DATA_WIDTH-1:0];
    assign flag_carry  = alu_carry;
    assign flag_eq     = (src1_reg == src2_reg);
    assign flag_lt     = ($signed(src1_reg) < $signed(src2_reg));
    assign instr_addr  = pc_reg;
    assign instruction = ir_reg;

`ifdef COMMON_BUS_DP_CYCLE_COUNT_EN
    logic [15:0] retired_reg;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            retired_reg <= '0;
        else if (ir_load_en)
            retired_reg <= retired_reg + 16'd1;
    end
    assign retired_count = retired_reg;
`endif

endmodule

// File: tb/tb_common_bus_datapath.sv
// Directed-vector bench for common_bus_datapath; one line per checked transaction.
`timescale 1ns/1ps
module tb_common_bus_datapath;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  data_bus_sel;
    logic [1:0]  reg_address;
    logic        pc_load_en, ir_load_en, rf_write_read;
    logic        alu_src1_load_en, alu_src2_load_en, sel_field_load_en;
    logic [7:0]  instr_addr;
    logic [13:0] instr_rdata;
    logic [13:0] instruction;
    logic        flag_eq, flag_lt, flag_carry;
    logic [7:0]  bus_value;
`ifdef COMMON_BUS_DP_CYCLE_COUNT_EN
    logic [15:0] retired_count;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clock = ~clock;

    common_bus_datapath dut (
        .clock(clock), .reset_n(reset_n),
        .data_bus_sel(data_bus_sel), .reg_address(reg_address),
        .pc_load_en(pc_load_en), .ir_load_en(ir_load_en), .rf_write_read(rf_write_read),
        .alu_src1_load_en(alu_src1_load_en), .alu_src2_load_en(alu_src2_load_en),
        .sel_field_load_en(sel_field_load_en),
        .instr_addr(instr_addr), .instr_rdata(instr_rdata), .instruction(instruction),
        .flag_eq(flag_eq), .flag_lt(flag_lt), .flag_carry(flag_carry),
`ifdef COMMON_BUS_DP_CYCLE_COUNT_EN
        .retired_count(retired_count),
`endif
        .bus_value(bus_value)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
            $display("ok   %-14s got 0x%0h", tag, obs);
        end else begin
            $display("FAIL %-14s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; enables drop back to idle after each cycle.
    task automatic cycle();
        @(posedge clock);
        #1;
        pc_load_en = 0; ir_load_en = 0; rf_write_read = 0;
        alu_src1_load_en = 0; alu_src2_load_en = 0; sel_field_load_en = 0;
    endtask

    task automatic fetch(input logic [13:0] word);
        instr_rdata = word;
        ir_load_en  = 1;
        cycle();
    endtask

    task automatic read_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        data_bus_sel = 2'b01;
        reg_address  = idx;
        #1;
        check(tag, bus_value, exp);
    endtask

    initial begin
        reset_n = 0; data_bus_sel = 0; reg_address = 0; instr_rdata = 0;
        pc_load_en = 0; ir_load_en = 0; rf_write_read = 0;
        alu_src1_load_en = 0; alu_src2_load_en = 0; sel_field_load_en = 0;
        #12;
        check("rst_pc", instr_addr, 8'h00);
        check("rst_ir", instruction, 14'h0);
        check("rst_eq", flag_eq, 1);
        check("rst_lt", flag_lt, 0);
        check("rst_carry", flag_carry, 0);
        @(posedge clock); #1;
        reset_n = 1;
        for (int i = 0; i < 4; i++) read_reg($sformatf("rst_r%0d", i), 2'(i), 8'h00);

        // Fetch sequence
        fetch(14'h0A05);
        check("fetch_ir", instruction, 14'h0A05);
        check("fetch_pc1", instr_addr, 8'h01);
        fetch(14'h0A05);
        check("fetch_pc2", instr_addr, 8'h02);
        data_bus_sel = 2'b00; #1;
        check("bus_pc", bus_value, 8'h02);

        // r1 = 5, r2 = 3, r3 = r1 + r2
        fetch(14'h0005);
        data_bus_sel = 2'b11; reg_address = 1; rf_write_read = 1; sel_field_load_en = 1;
        cycle();
        fetch(14'h0003);
        data_bus_sel = 2'b11; reg_address = 2; rf_write_read = 1;
        cycle();
        data_bus_sel = 2'b01; reg_address = 1; alu_src1_load_en = 1;
        cycle();
        data_bus_sel = 2'b01; reg_address = 2; alu_src2_load_en = 1;
        cycle();
        data_bus_sel = 2'b10; reg_address = 3; #1;
        check("add_bus", bus_value, 8'h08);
        check("add_carry", flag_carry, 0);
        rf_write_read = 1;
        cycle();
        read_reg("add_r3", 2'd3, 8'h08);
        read_reg("keep_r1", 2'd1, 8'h05);

        // 0xFF + 0x01
        fetch(14'h00FF);
        data_bus_sel = 2'b11; alu_src1_load_en = 1;
        cycle();
        fetch(14'h0001);
        data_bus_sel = 2'b11; alu_src2_load_en = 1;
        cycle();
        data_bus_sel = 2'b10; #1;
        check("addw_bus", bus_value, 8'h00);
        check("addw_carry", flag_carry, 1);
        check("ff01_eq", flag_eq, 0);
        check("ff01_lt", flag_lt, 1);

        // Swap: src1 = 0x01, src2 = 0xFF
        data_bus_sel = 2'b11; alu_src1_load_en = 1;
        cycle();
        fetch(14'h00FF);
        data_bus_sel = 2'b11; alu_src2_load_en = 1;
        cycle();
        check("01ff_lt", flag_lt, 0);
        check("01ff_eq", flag_eq, 0);

        // SUB 0x01 - 0xFF
        fetch(14'h0800);
        sel_field_load_en = 1;
        cycle();
        data_bus_sel = 2'b10; #1;
        check("sub_bus", bus_value, 8'h02);
        check("sub_borrow", flag_carry, 1);

        // Same-cycle fetch and function latch: function comes from the old IR (SUB)
        instr_rdata = 14'h2000; ir_load_en = 1; sel_field_load_en = 1;
        cycle();
        data_bus_sel = 2'b10; #1;
        check("func_old_ir", bus_value, 8'h02);
        sel_field_load_en = 1;
        cycle();
        #1;
        check("or_bus", bus_value, 8'hFF);
        check("or_carry", flag_carry, 0);

        // PC load wins over increment
        fetch(14'h0040);
        data_bus_sel = 2'b11; pc_load_en = 1; ir_load_en = 1; instr_rdata = 14'h1234;
        cycle();
        check("pcld_pc", instr_addr, 8'h40);
        check("pcld_ir", instruction, 14'h1234);

        // PC wrap
        fetch(14'h00FF);
        data_bus_sel = 2'b11; pc_load_en = 1;
        cycle();
        check("pc_ff", instr_addr, 8'hFF);
        fetch(14'h00FF);
        check("pc_wrap", instr_addr, 8'h00);

        // Mid-sequence asynchronous reset
        data_bus_sel = 2'b11; reg_address = 0; rf_write_read = 1;
        cycle();
        read_reg("r0_wr", 2'd0, 8'hFF);
        #2 reset_n = 0;
        #1;
        check("arst_pc", instr_addr, 8'h00);
        check("arst_ir", instruction, 14'h0);
        check("arst_eq", flag_eq, 1);
        check("arst_lt", flag_lt, 0);
        read_reg("arst_r0", 2'd0, 8'h00);
        read_reg("arst_r3", 2'd3, 8'h00);
        @(posedge clock); #1;
        reset_n = 1;

`ifdef COMMON_BUS_DP_CYCLE_COUNT_EN
        fetch(14'h0001);
        fetch(14'h0002);
        fetch(14'h0003);
        check("retired_3", retired_count, 16'd3);
        #2 reset_n = 0;
        #1;
        check("retired_rst", retired_count, 16'd0);
        @(posedge clock); #1;
        reset_n = 1;
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
